// File: rtl/sram_sdp_pipe.sv
// rtl/sram_sdp_pipe.sv - simple dual-port SRAM with write-first bypass, 1/2-cycle read pipe and clear-on-reset
module sram_sdp_pipe #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32,
  parameter int ADDR_WIDTH = (RAM_DEPTH <= 2) ? 1 : $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = 1,
  parameter int INIT_ON_RESET = 1,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [RAM_WIDTH-1:0]  doutb,
  output logic                  doutb_valid,
  output logic                  init_done
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_sdp_pipe: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {INIT, RUN} state_t;
  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  state_t state, state_next;
  logic [ADDR_WIDTH:0] cnt, cnt_next;
  logic init_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_we    = 1'b0;
    if (state == INIT) begin
      init_we  = 1'b1;
      cnt_next = cnt + 1'b1;
      if (cnt == LAST_ADDR) state_next = RUN;
    end
  end

  assign init_done = (state == RUN) && !rst;

  logic wr_ok, rd_ok, rd_in_range, wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_WIDTH-1:0] wr_data, rd_word;

  assign wr_ok       = init_done && wea && ({1'b0, addra} < DEPTH_W);
  assign rd_ok       = init_done && reb;
  assign rd_in_range = {1'b0, addrb} < DEPTH_W;
  assign wr_en       = init_we || wr_ok;
  assign wr_addr     = init_we ? cnt[ADDR_WIDTH-1:0] : addra;
  assign wr_data     = init_we ? INIT_VALUE : dina;

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-edge write to the read address is bypassed so reads see write-first data
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (wr_ok && addra == addrb) rd_word = dina;
      else rd_word = mem[addrb];
    end
  end

  logic s1_valid;
  logic [RAM_WIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_data <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic s2_valid;
    logic [RAM_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign doutb       = s2_data;
    assign doutb_valid = s2_valid;
  end else begin : g_lat1
    assign doutb       = s1_data;
    assign doutb_valid = s1_valid;
  end

endmodule

// File: tb/tb_sram_sdp_pipe.sv
// tb/tb_sram_sdp_pipe.sv - directed bench for sram_sdp_pipe at LAT=1/2 and DEPTH=32/24
module tb_sram_sdp_pipe;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst, wea, reb;
  logic [4:0] addra, addrb;
  logic [31:0] dina;
  logic [31:0] dout1, dout2, dout3;
  logic v1, v2, v3, d1, d2, d3;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_sdp_pipe #(.RAM_WIDTH(32), .RAM_DEPTH(32), .READ_LATENCY(1), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u1 (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .reb(reb), .addrb(addrb),
    .doutb(dout1), .doutb_valid(v1), .init_done(d1));
  sram_sdp_pipe #(.RAM_WIDTH(32), .RAM_DEPTH(32), .READ_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u2 (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .reb(reb), .addrb(addrb),
    .doutb(dout2), .doutb_valid(v2), .init_done(d2));
  sram_sdp_pipe #(.RAM_WIDTH(32), .RAM_DEPTH(24), .READ_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u3 (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .reb(reb), .addrb(addrb),
    .doutb(dout3), .doutb_valid(v3), .init_done(d3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  initial begin
    int t1, t2, t3, nvalid;
    rst = 1'b1; wea = 1'b0; reb = 1'b0; addra = '0; addrb = '0; dina = '0;
    tick(); tick();
    check("rst_dout1", dout1, 0);
    check("rst_valid1", 32'(v1), 0);
    check("rst_done1", 32'(d1), 0);
    check("rst_dout2", dout2, 0);
    check("rst_done3", 32'(d3), 0);

    // Release reset with reads requested during INIT
    rst = 1'b0; addrb = 5'd5;
    t1 = 0; t2 = 0; t3 = 0; nvalid = 0;
    for (int i = 1; i <= 40; i++) begin
      reb = (i < 24);
      tick();
      if (d1 && t1 == 0) t1 = i;
      if (d2 && t2 == 0) t2 = i;
      if (d3 && t3 == 0) t3 = i;
      nvalid += int'(v1) + int'(v2) + int'(v3);
    end
    reb = 1'b0;
    check("init_cycles_u1", 32'(t1), 32);
    check("init_cycles_u2", 32'(t2), 32);
    check("init_cycles_u3", 32'(t3), 24);
    check("no_valid_during_init", 32'(nvalid), 0);

    // Clear-then-read of address 5
    reb = 1'b1; addrb = 5'd5;
    tick();
    reb = 1'b0;
    check("clr_v1", 32'(v1), 1);
    check("clr_d1", dout1, IV);
    check("clr_v2_early", 32'(v2), 0);
    tick();
    check("clr_v2", 32'(v2), 1);
    check("clr_d2", dout2, IV);
    check("clr_v1_one_pulse", 32'(v1), 0);
    check("clr_d1_hold", dout1, IV);

    // Write then read address 3
    wea = 1'b1; addra = 5'd3; dina = 32'h12345678;
    tick();
    wea = 1'b0; reb = 1'b1; addrb = 5'd3;
    tick();
    reb = 1'b0;
    check("wr_v1", 32'(v1), 1);
    check("wr_d1", dout1, 32'h12345678);
    check("wr_v2_early", 32'(v2), 0);
    tick();
    check("wr_v2", 32'(v2), 1);
    check("wr_d2", dout2, 32'h12345678);
    check("wr_v1_off", 32'(v1), 0);

    // Collision at address 7, then a later write must not leak into LAT=2 result
    wea = 1'b1; addra = 5'd7; dina = 32'h1;
    tick();
    dina = 32'h2; reb = 1'b1; addrb = 5'd7;
    tick();
    check("col_d1", dout1, 32'h2);
    check("col_v1", 32'(v1), 1);
    dina = 32'h3; reb = 1'b0;
    tick();
    wea = 1'b0;
    check("col_d2", dout2, 32'h2);
    check("col_v2", 32'(v2), 1);
    reb = 1'b1;
    tick();
    reb = 1'b0;
    check("col_after_d1", dout1, 32'h3);

    // Distinct writes to all 32 addresses, then back-to-back reads
    wea = 1'b1;
    for (int a = 0; a < 32; a++) begin
      addra = 5'(a); dina = 32'hC000_0000 + 32'(a);
      tick();
    end
    wea = 1'b0;
    for (int i = 0; i < 34; i++) begin
      reb = (i < 32); addrb = 5'(i);
      tick();
      if (i < 32) begin
        check($sformatf("b2b_v1_%0d", i), 32'(v1), 1);
        check($sformatf("b2b_d1_%0d", i), dout1, 32'hC000_0000 + 32'(i));
      end
      if (i >= 1 && i <= 32) begin
        check($sformatf("b2b_v2_%0d", i - 1), 32'(v2), 1);
        check($sformatf("b2b_d2_%0d", i - 1), dout2, 32'hC000_0000 + 32'(i - 1));
        check($sformatf("b2b_v3_%0d", i - 1), 32'(v3), 1);
        check($sformatf("b2b_d3_%0d", i - 1), dout3, (i - 1 < 24) ? 32'hC000_0000 + 32'(i - 1) : 32'h0);
      end
    end
    reb = 1'b0;
    check("b2b_v2_end", 32'(v2), 0);

    // Out-of-range write on the 24-deep instance
    wea = 1'b1; addra = 5'd30; dina = 32'hFF;
    tick();
    wea = 1'b0; reb = 1'b1; addrb = 5'd30;
    tick(); reb = 1'b0; tick();
    check("oor_v3", 32'(v3), 1);
    check("oor_d3", dout3, 32'h0);
    check("oor_d2_inrange", dout2, 32'hFF);

    // Reset one cycle after a LAT=2 read
    reb = 1'b1; addrb = 5'd3;
    tick();
    reb = 1'b0; rst = 1'b1;
    tick();
    check("mrst_v2", 32'(v2), 0);
    check("mrst_d2", dout2, 0);
    check("mrst_d1", dout1, 0);
    check("mrst_done2", 32'(d2), 0);
    rst = 1'b0;
    t2 = 0; t3 = 0; nvalid = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (d2 && t2 == 0) t2 = i;
      if (d3 && t3 == 0) t3 = i;
      nvalid += int'(v1) + int'(v2) + int'(v3);
    end
    check("mrst_init_u2", 32'(t2), 32);
    check("mrst_init_u3", 32'(t3), 24);
    check("mrst_no_valid", 32'(nvalid), 0);
    reb = 1'b1; addrb = 5'd3;
    tick(); reb = 1'b0; tick();
    check("mrst_reinit_d2", dout2, IV);
    check("mrst_reinit_d3", dout3, IV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
